aes_host_ctrl: RTL



---
 rtl/aes_host_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/aes_host_ctrl.sv
// Requester-side sequencer for the AES core command handshake: accepts key/enc/dec
// requests, issues one at a time, enforces a response timeout and returns results.
module aes_host_ctrl #(
   parameter int unsigned TIMEOUT = 4096,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_op,
   input  logic [255:0]       req_data,
   output logic               core_input_valid,
   input  logic               core_input_ready,
   output logic [6:0]         core_opcode,
   output logic [255:0]       core_data_in,
   input  logic               core_output_valid,
   output logic               core_output_ready,
   input  logic [127:0]       core_data_out,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [1:0]         rsp_op,
   output logic [127:0]       rsp_data,
   output logic               rsp_err,
   output logic               key_loaded,
   output logic               timeout_seen,
   output logic               busy,
   output logic [CNT_W-1:0]   ops_done,
   output logic [CNT_W-1:0]   ops_err
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   localparam logic [1:0] OP_KEY = 2'd0;
   localparam logic [1:0] OP_ILL = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t             state, state_d;
   logic [1:0]         op_q, op_d;
   logic [255:0]       data_q, data_d;
   logic [127:0]       rdata_q, rdata_d;
   logic               err_q, err_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               key_d, tseen_d;
   logic [CNT_W-1:0]   done_d, errc_d;

   assign core_opcode  = 7'(op_q);
   assign core_data_in = data_q;
   assign rsp_op       = op_q;
   assign rsp_data     = rdata_q;
   assign rsp_err      = err_q;

   // State, payload and registered handshake outputs (decoded from next state)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         op_q              <= '0;
         data_q            <= '0;
         rdata_q           <= '0;
         err_q             <= 1'b0;
         timer_q           <= '0;
         key_loaded        <= 1'b0;
         timeout_seen      <= 1'b0;
         ops_done          <= '0;
         ops_err           <= '0;
         req_ready         <= 1'b1;
         core_input_valid  <= 1'b0;
         core_output_ready <= 1'b0;
         rsp_valid         <= 1'b0;
         busy              <= 1'b0;
      end else begin
         state             <= state_d;
         op_q              <= op_d;
         data_q            <= data_d;
         rdata_q           <= rdata_d;
         err_q             <= err_d;
         timer_q           <= timer_d;
         key_loaded        <= key_d;
         timeout_seen      <= tseen_d;
         ops_done          <= done_d;
         ops_err           <= errc_d;
         req_ready         <= (state_d == IDLE);
         core_input_valid  <= (state_d == ISSUE);
         core_output_ready <= (state_d == WAIT);
         rsp_valid         <= (state_d == RESP);
         busy              <= (state_d != IDLE);
      end
   end

   // Next-state and next-register logic
   always_comb begin
      state_d = state;
      op_d    = op_q;
      data_d  = data_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      timer_d = timer_q;
      key_d   = key_loaded;
      tseen_d = timeout_seen;
      done_d  = ops_done;
      errc_d  = ops_err;

      unique case (state)
         IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               data_d  = (req_op == OP_KEY) ? req_data : {req_data[255:128], 128'd0};
               rdata_d = '0;
               if ((req_op == OP_ILL) || ((req_op != OP_KEY) && !key_loaded)) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (core_input_ready) begin
               timer_d = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // A result arriving on the timeout cycle takes priority
            if (core_output_valid) begin
               rdata_d = (op_q == OP_KEY) ? 128'd0 : core_data_out;
               err_d   = 1'b0;
               if (op_q == OP_KEY) key_d = 1'b1;
               state_d = RESP;
            end else if (timer_q == TMR_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               tseen_d = 1'b1;
               key_d   = 1'b0;
               state_d = RESP;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               if (err_q) errc_d = ops_err + CNT_W'(1);
               else       done_d = ops_done + CNT_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
